// File: rtl/mips_ctrl_pkg.sv
// Shared state encoding for the MIPS step controller and its helpers.
package mips_ctrl_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2,
        S_BRK  = 2'd3
    } state_t;
endpackage

// File: rtl/mips_run_divider.sv
// Free-run rate divider: counts while enabled and flags the last count of each period.
module mips_run_divider #(
    parameter int RUN_DIV = 25000000,
    parameter int DIV_W   = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam logic [DIV_W-1:0] TC_VALUE = DIV_W'(RUN_DIV - 1);

    logic [DIV_W-1:0] count_reg;

    assign tc = (count_reg == TC_VALUE);

    // Clear outranks enable so a stop/start always restarts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end
endmodule

// File: rtl/mips_step_controller.sv
// Generates single-cycle CPU clock enables for step, free-run and breakpoint-halt operation.
module mips_step_controller
    import mips_ctrl_pkg::*;
#(
    parameter int RUN_DIV = 25000000,
    parameter int DIV_W   = 26,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STEP,
    input  logic               RUN,
    input  logic               BRK_EN,
    input  logic [PC_W-1:0]    BRK_ADDR,
    input  logic [PC_W-1:0]    PC,
    output logic               CPU_EN,
    output logic [STATE_W-1:0] STATE,
    output logic               HALT,
    output logic               BUSY,
    output logic [CNT_W-1:0]   CYCLES
);
    state_t           state_reg, state_next;
    logic             cpu_en_reg, cpu_en_next;
    logic             skip_reg, skip_next;
    logic [CNT_W-1:0] cycles_reg;
    logic             div_clear, div_enable, div_tc;

    mips_run_divider #(
        .RUN_DIV (RUN_DIV),
        .DIV_W   (DIV_W)
    ) u_divider (
        .clk    (CLK),
        .rst_n  (RST),
        .clear  (div_clear),
        .enable (div_enable),
        .tc     (div_tc)
    );

    always_comb begin
        state_next  = state_reg;
        cpu_en_next = 1'b0;
        skip_next   = skip_reg;
        div_clear   = 1'b0;
        div_enable  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (RUN) begin
                    state_next = S_RUN;
                    div_clear  = 1'b1;
                    skip_next  = 1'b0;
                end else if (STEP) begin
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                cpu_en_next = 1'b1;
                state_next  = S_IDLE;
            end
            S_RUN: begin
                if (RUN) begin
                    state_next = S_IDLE;
                    div_clear  = 1'b1;
                end else begin
                    div_enable = 1'b1;
                    // PC has had a full divider period to settle by terminal count.
                    if (div_tc) begin
                        if (BRK_EN && !skip_reg && (PC == BRK_ADDR)) begin
                            state_next = S_BRK;
                        end else begin
                            cpu_en_next = 1'b1;
                            skip_next   = 1'b0;
                        end
                    end
                end
            end
            S_BRK: begin
                if (RUN) begin
                    state_next = S_RUN;
                    div_clear  = 1'b1;
                    skip_next  = 1'b1;
                end else if (STEP) begin
                    state_next = S_STEP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg  <= S_IDLE;
            cpu_en_reg <= 1'b0;
            skip_reg   <= 1'b0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cpu_en_reg <= cpu_en_next;
            skip_reg   <= skip_next;
            if (cpu_en_reg) begin
                cycles_reg <= cycles_reg + 1'b1;
            end
        end
    end

    assign CPU_EN = cpu_en_reg;
    assign STATE  = state_reg;
    assign HALT   = (state_reg == S_BRK);
    assign BUSY   = (state_reg == S_STEP) || (state_reg == S_RUN);
    assign CYCLES = cycles_reg;
endmodule

// File: doc/mips_step_controller.md
Name: mips_step_controller

Overview:
- Sequences the single-cycle MIPS core on the DE10-Lite board, replacing direct use of a debounced button as the CPU clock.
- Issues one-CLK-wide clock-enable pulses to the CPU in three modes: single-step, free-run at a divided rate, and halt-on-breakpoint (PC match).
- Sits between the debounced button outputs and the CPU clock-enable; its state and cycle count feed the display selector.

Parameters:
- RUN_DIV, 25000000, CLK cycles between CPU_EN pulses in RUN mode (2 Hz at 50 MHz); legal range 2..2^DIV_W-1.
- DIV_W, 26, width of the run-rate divider counter.
- PC_W, 32, width of PC and BRK_ADDR.
- CNT_W, 16, width of the CYCLES counter.

Ports:
- CLK  in  1  system clock (MAX10_CLK1_50).
- RST  in  1  asynchronous, active-low reset.
- STEP  in  1  single-CLK pulse from the debounced button: request one instruction.
- RUN  in  1  single-CLK pulse: toggle free-run / stop.
- BRK_EN  in  1  level: breakpoint compare enabled.
- BRK_ADDR  in  PC_W  breakpoint byte address.
- PC  in  PC_W  current PC from the CPU.
- CPU_EN  out  1  registered clock enable; the CPU executes one instruction per high cycle.
- STATE  out  2  FSM state encoding.
- HALT  out  1  high while in S_BRK.
- BUSY  out  1  high in S_STEP or S_RUN.
- CYCLES  out  CNT_W  count of CPU_EN pulses issued since reset.

Behaviour:
- Reset (RST=0, asynchronous): STATE=S_IDLE, CPU_EN=0, HALT=0, BUSY=0, CYCLES=0, divider=0, skip flag=0. RST low mid-run aborts immediately; no partial pulse.
- Encoding: S_IDLE=0, S_STEP=1, S_RUN=2, S_BRK=3.
- S_IDLE:
  - RUN → S_RUN, divider cleared.
  - Else STEP → S_STEP.
  - RUN and STEP in the same cycle: RUN wins, STEP is dropped.
- S_STEP:
  - CPU_EN=1 for exactly this one cycle, then return unconditionally to S_IDLE.
  - Breakpoint is not checked.
  - STEP/RUN inputs arriving during S_STEP are ignored.
- Step latency: STEP sampled at edge k → CPU_EN high from edge k+1 to edge k+2.
- S_RUN:
  - Divider increments each cycle.
  - At divider==RUN_DIV-1: divider→0, then:
    - If BRK_EN=1, skip flag=0 and PC==BRK_ADDR → S_BRK with no CPU_EN pulse.
    - Otherwise CPU_EN pulses for one cycle and the skip flag clears.
  - RUN pulse → S_IDLE, divider cleared. If it coincides with terminal count, stop wins and no pulse is issued.
  - STEP is ignored.
- S_BRK:
  - HALT=1, CPU_EN=0.
  - STEP → S_STEP (steps past the breakpoint).
  - RUN → S_RUN with divider cleared and skip flag=1, so the first compare after resume is suppressed; this prevents re-halting on the same PC.
  - RUN and STEP together: RUN wins.
  - Deasserting BRK_EN does not leave S_BRK.
- PC is compared only at terminal count. RUN_DIV≥2 guarantees PC has settled after the previous CPU_EN edge.
- CYCLES increments on every CPU_EN=1 cycle. It wraps 2^CNT_W-1 → 0 silently.
- CPU_EN is never high in two consecutive cycles.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state localparams S_IDLE/S_STEP/S_RUN/S_BRK;
  - the 2-bit state width constant.
- Sub-module mips_run_divider contains:
  - the DIV_W counter;
  - inputs for clear and enable;
  - a terminal-count output that is high when count==RUN_DIV-1.
- The FSM, skip flag, compare and CYCLES counter stay in mips_step_controller.

Test Plan (RUN_DIV=4, CNT_W=4 unless stated):
- Reset: hold RST=0 for 3 cycles, release → STATE=0, CPU_EN=0, CYCLES=0, HALT=0; asserting RST=0 mid-S_RUN returns STATE=0 within the same cycle.
- Single step: STEP pulse at edge 10 → CPU_EN high only during cycle 11, STATE 1 then 0, CYCLES=1; three STEPs → CYCLES=3.
- Free run: RUN pulse → CPU_EN pulses every 4th cycle; 8 pulses → CYCLES=8; RUN pulse again → STATE=0, no further pulses.
- Breakpoint: BRK_EN=1, BRK_ADDR=0x0000000C, PC model advances by 4 per CPU_EN from 0 → three pulses (PC 0,4,8→0xC), then STATE=3, HALT=1, CYCLES=3, PC stays 0xC.
- Resume and step-over:
  - From S_BRK, RUN → next pulse issued at PC=0xC, no re-halt; PC reaches 0x10, CYCLES=4.
  - Separately, STEP in S_BRK → exactly one pulse, STATE=0.
- Priority and wrap:
  - RUN+STEP same cycle in S_IDLE → STATE=2, no STEP pulse.
  - RUN at terminal count in S_RUN → no pulse, STATE=0.
  - 17 pulses → CYCLES=1.
